// File: rtl/instr_stream_encoder_if.sv
// Symbolic-instruction stream between a program source and the encoder.
// The source drives the fields and in_valid. The encoder returns in_ready.
interface instr_stream_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// Encodes symbolic instructions into 32-bit MIPS words and writes them to
// consecutive instruction-memory addresses. The finish pulse appends an
// optional terminating NOP, written only while space remains.
module instr_stream_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   finish,
  instr_stream_encoder_if.slave  stream,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [ADDR_W:0]        count,
  output logic                   done,
  output logic                   overflow
);

  localparam logic [31:0] NOP_WORD = 32'hFC000000;

  typedef enum logic [1:0] {IDLE, LOAD, TERM, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]         mem_wdata_reg, mem_wdata_next;
  logic                overflow_reg, overflow_next;
  logic                full;
  logic [31:0]         enc_word;

  // The count saturates at DEPTH, so its top bit alone marks "memory full".
  assign full = count_reg[ADDR_W];

  // Translate the symbolic kind and its fields into a machine word.
  always_comb begin
    enc_word = NOP_WORD;
    case (stream.in_kind)
      3'd0: enc_word = {6'd0, stream.in_rs, stream.in_rt, stream.in_rd,
                        stream.in_shamt, stream.in_funct};
      3'd1: enc_word = {6'd35, stream.in_rs, stream.in_rt, stream.in_imm};
      3'd2: enc_word = {6'd43, stream.in_rs, stream.in_rt, stream.in_imm};
      3'd3: enc_word = {6'd13, stream.in_rs, stream.in_rt, stream.in_imm};
      3'd4: enc_word = {6'd4,  stream.in_rs, stream.in_rt, stream.in_imm};
      3'd5: enc_word = {6'd5,  stream.in_rs, stream.in_rt, stream.in_imm};
      3'd6: enc_word = {6'd2,  stream.in_target};
      default: enc_word = NOP_WORD;
    endcase
  end

  // Next-state and datapath decisions.
  // If start arrives together with an accepted word, start wins and the
  // word is dropped, because the program is being restarted.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    overflow_next  = overflow_reg;
    if (start) begin
      state_next    = LOAD;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (stream.in_valid) begin
            if (full) begin
              overflow_next = 1'b1;
            end else begin
              mem_we_next    = 1'b1;
              mem_addr_next  = count_reg[ADDR_W-1:0];
              mem_wdata_next = enc_word;
              count_next     = count_reg + (ADDR_W+1)'(1);
            end
          end
          if (finish) state_next = TERM;
        end
        TERM: begin
          if (!full) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = count_reg[ADDR_W-1:0];
            mem_wdata_next = NOP_WORD;
            count_next     = count_reg + (ADDR_W+1)'(1);
          end
          state_next = DONE;
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign stream.in_ready = (state_reg == LOAD) && !full;
  assign mem_we          = mem_we_reg;
  assign mem_addr        = mem_addr_reg;
  assign mem_wdata       = mem_wdata_reg;
  assign count           = count_reg;
  assign done            = (state_reg == DONE);
  assign overflow        = overflow_reg;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder.
// Instance A uses 64 words and covers encoding, termination, restart and reset.
// Instance B uses 4 words and covers the full/overflow corner.
module tb_instr_stream_encoder;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, finish_a, start_b, finish_b;
  logic        we_a, done_a, ovf_a, we_b, done_b, ovf_b;
  logic [5:0]  addr_a;
  logic [1:0]  addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [6:0]  count_a;
  logic [2:0]  count_b;

  instr_stream_encoder_if ifa ();
  instr_stream_encoder_if ifb ();

  instr_stream_encoder #(.ADDR_W(6)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .finish(finish_a), .stream(ifa),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .count(count_a),
    .done(done_a), .overflow(ovf_a)
  );

  instr_stream_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .finish(finish_b), .stream(ifb),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .count(count_b),
    .done(done_b), .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding built by place-value arithmetic from the field layout.
  function automatic logic [31:0] ref_word(input instr_t t);
    int unsigned op;
    case (t.kind)
      3'd0: return 32'(t.rs) * (1 << 21) + 32'(t.rt) * (1 << 16) + 32'(t.rd) * (1 << 11)
                 + 32'(t.shamt) * (1 << 6) + 32'(t.funct);
      3'd6: return 32'd2 * (1 << 26) + 32'(t.target);
      3'd7: return 32'd63 * (1 << 26);
      default: begin
        op = (t.kind == 3'd1) ? 35 : (t.kind == 3'd2) ? 43 : (t.kind == 3'd3) ? 13 :
             (t.kind == 3'd4) ? 4 : 5;
        return op * (1 << 26) + 32'(t.rs) * (1 << 21) + 32'(t.rt) * (1 << 16) + 32'(t.imm);
      end
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.kind   = 3'($urandom);
    t.rs     = 5'($urandom);
    t.rt     = 5'($urandom);
    t.rd     = 5'($urandom);
    t.shamt  = 5'($urandom);
    t.funct  = 6'($urandom);
    t.imm    = 16'($urandom);
    t.target = 26'($urandom);
    return t;
  endfunction

  function automatic instr_t mk(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [25:0] tg);
    instr_t t;
    t.kind = k; t.rs = rs; t.rt = rt; t.rd = rd; t.shamt = sh; t.funct = fn;
    t.imm = imm; t.target = tg;
    return t;
  endfunction

  task automatic drive_a(input instr_t t, input logic v);
    ifa.in_valid = v; ifa.in_kind = t.kind; ifa.in_rs = t.rs; ifa.in_rt = t.rt;
    ifa.in_rd = t.rd; ifa.in_shamt = t.shamt; ifa.in_funct = t.funct;
    ifa.in_imm = t.imm; ifa.in_target = t.target;
  endtask

  task automatic drive_b(input instr_t t, input logic v);
    ifb.in_valid = v; ifb.in_kind = t.kind; ifb.in_rs = t.rs; ifb.in_rt = t.rt;
    ifb.in_rd = t.rd; ifb.in_shamt = t.shamt; ifb.in_funct = t.funct;
    ifb.in_imm = t.imm; ifb.in_target = t.target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  // One accepted word on A, expected at address a with word w.
  task automatic push_a(input string tag, input instr_t t, input int a, input logic [31:0] w);
    drive_a(t, 1'b1);
    tick();
    $display("txn %s: addr=%0d wdata=%08h we=%0b", tag, addr_a, wdata_a, we_a);
    check({tag, "_we"}, 64'(we_a), 64'd1);
    check({tag, "_addr"}, 64'(addr_a), 64'(a));
    check({tag, "_wdata"}, 64'(wdata_a), 64'(w));
  endtask

  vec_t   vecs [8];
  instr_t t;
  int     exp_count;
  logic   v;

  initial begin
    vecs[0] = '{mk(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0), 32'h00221820};
    vecs[1] = '{mk(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0), 32'h8FA80004};
    vecs[2] = '{mk(3'd3, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0), 32'h3409FFFF};
    vecs[3] = '{mk(3'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0), 32'h1422FFFE};
    vecs[4] = '{mk(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10), 32'h08000010};
    vecs[5] = '{mk(3'd2, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0), 32'hAC430008};
    vecs[6] = '{mk(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0), 32'h10850010};
    vecs[7] = '{mk(3'd7, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h3FFFFFF), 32'hFC000000};

    rst = 1'b1; start_a = 1'b0; finish_a = 1'b0; start_b = 1'b0; finish_b = 1'b0;
    drive_a(vecs[0].ins, 1'b0);
    drive_b(vecs[0].ins, 1'b0);
    tick(); tick();

    // Reset values.
    check("rst_we", 64'(we_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_wdata", 64'(wdata_a), 64'd0);
    check("rst_count", 64'(count_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    check("rst_ready", 64'(ifa.in_ready), 64'd0);
    check("rst_ready_b", 64'(ifb.in_ready), 64'd0);
    rst = 1'b0;

    // Valid in IDLE is ignored.
    drive_a(vecs[0].ins, 1'b1);
    tick();
    check("idle_we", 64'(we_a), 64'd0);
    check("idle_ovf", 64'(ovf_a), 64'd0);
    drive_a(vecs[0].ins, 1'b0);

    pulse_start_a();
    check("start_ready", 64'(ifa.in_ready), 64'd1);
    check("start_count", 64'(count_a), 64'd0);

    // Back-to-back table of encodings.
    for (int i = 0; i < 8; i++) push_a($sformatf("vec%0d", i), vecs[i].ins, i, vecs[i].exp);
    drive_a(vecs[0].ins, 1'b0);
    tick();
    check("idle_gap_we", 64'(we_a), 64'd0);
    check("hold_addr", 64'(addr_a), 64'd7);
    check("hold_wdata", 64'(wdata_a), 64'h00000000FC000000);
    check("table_count", 64'(count_a), 64'd8);

    // finish together with an accept: word then NOP on consecutive cycles.
    finish_a = 1'b1;
    push_a("fin_acc", vecs[0].ins, 8, 32'h00221820);
    finish_a = 1'b0;
    drive_a(vecs[0].ins, 1'b0);
    tick();
    $display("txn term: addr=%0d wdata=%08h we=%0b", addr_a, wdata_a, we_a);
    check("term_we", 64'(we_a), 64'd1);
    check("term_addr", 64'(addr_a), 64'd9);
    check("term_wdata", 64'(wdata_a), 64'h00000000FC000000);
    check("term_count", 64'(count_a), 64'd10);
    check("term_done", 64'(done_a), 64'd1);
    check("term_ready", 64'(ifa.in_ready), 64'd0);

    // finish and in_valid while DONE are ignored.
    finish_a = 1'b1;
    drive_a(vecs[1].ins, 1'b1);
    tick();
    finish_a = 1'b0;
    drive_a(vecs[1].ins, 1'b0);
    check("done_we", 64'(we_a), 64'd0);
    check("done_ovf", 64'(ovf_a), 64'd0);
    check("done_count", 64'(count_a), 64'd10);
    check("done_hold", 64'(done_a), 64'd1);

    // Restart, three words, then finish with no accept.
    pulse_start_a();
    check("restart_count", 64'(count_a), 64'd0);
    check("restart_done", 64'(done_a), 64'd0);
    for (int i = 0; i < 3; i++) begin
      t = rand_instr();
      push_a($sformatf("t4_%0d", i), t, i, ref_word(t));
    end
    drive_a(t, 1'b0);
    finish_a = 1'b1;
    tick();
    finish_a = 1'b0;
    check("t4_term_we", 64'(we_a), 64'd0);
    check("t4_term_done", 64'(done_a), 64'd0);
    tick();
    check("t4_nop_we", 64'(we_a), 64'd1);
    check("t4_nop_addr", 64'(addr_a), 64'd3);
    check("t4_nop_wdata", 64'(wdata_a), 64'h00000000FC000000);
    check("t4_count", 64'(count_a), 64'd4);
    check("t4_done", 64'(done_a), 64'd1);
    pulse_start_a();
    check("t4_restart_count", 64'(count_a), 64'd0);

    // Random gappy stream against the reference model.
    exp_count = 0;
    for (int c = 0; c < 60; c++) begin
      t = rand_instr();
      v = 1'($urandom_range(0, 1));
      drive_a(t, v);
      check("rnd_ready", 64'(ifa.in_ready), 64'(exp_count < 64));
      tick();
      if (v) begin
        $display("txn rnd: addr=%0d wdata=%08h we=%0b", addr_a, wdata_a, we_a);
        check("rnd_we", 64'(we_a), 64'd1);
        check("rnd_addr", 64'(addr_a), 64'(exp_count));
        check("rnd_wdata", 64'(wdata_a), 64'(ref_word(t)));
        exp_count++;
      end else begin
        check("rnd_idle_we", 64'(we_a), 64'd0);
      end
      check("rnd_count", 64'(count_a), 64'(exp_count));
    end

    // Reset in the middle of a stream.
    drive_a(rand_instr(), 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_we", 64'(we_a), 64'd0);
    check("midrst_count", 64'(count_a), 64'd0);
    check("midrst_ready", 64'(ifa.in_ready), 64'd0);
    check("midrst_addr", 64'(addr_a), 64'd0);
    rst = 1'b0;
    drive_a(vecs[0].ins, 1'b0);
    tick();
    check("midrst_idle_we", 64'(we_a), 64'd0);
    check("midrst_idle_done", 64'(done_a), 64'd0);

    // Small memory: five pushes with in_valid held, fifth overflows.
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t = rand_instr();
      drive_b(t, 1'b1);
      check("b_ready", 64'(ifb.in_ready), 64'(i < 4));
      tick();
      $display("txn b%0d: addr=%0d wdata=%08h we=%0b", i, addr_b, wdata_b, we_b);
      if (i < 4) begin
        check("b_we", 64'(we_b), 64'd1);
        check("b_addr", 64'(addr_b), 64'(i));
        check("b_wdata", 64'(wdata_b), 64'(ref_word(t)));
        check("b_ovf_clear", 64'(ovf_b), 64'd0);
      end else begin
        check("b_full_we", 64'(we_b), 64'd0);
        check("b_ovf", 64'(ovf_b), 64'd1);
      end
      check("b_count", 64'(count_b), 64'(i < 4 ? i + 1 : 4));
    end
    drive_b(t, 1'b0);
    check("b_full_ready", 64'(ifb.in_ready), 64'd0);
    finish_b = 1'b1; tick(); finish_b = 1'b0;
    tick();
    check("b_term_we", 64'(we_b), 64'd0);
    check("b_term_done", 64'(done_b), 64'd1);
    check("b_term_count", 64'(count_b), 64'd4);
    check("b_ovf_sticky", 64'(ovf_b), 64'd1);
    start_b = 1'b1; tick(); start_b = 1'b0;
    check("b_restart_ovf", 64'(ovf_b), 64'd0);
    check("b_restart_count", 64'(count_b), 64'd0);
    check("b_restart_done", 64'(done_b), 64'd0);
    check("b_restart_ready", 64'(ifb.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
